io_responder: RTL
=================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter SW_W, default 16, switch bank width.
REQ-002 SHALL have parameter LED_W, default 16, LED bank width.
REQ-003 SHALL have parameter DB_CNT, default 500000, debounce stability window in clk cycles; must be at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port io_read, input, 1, core IO-load request, held until the core advances.
REQ-007 SHALL have port io_write, input, 1, core IO-store request, held one instruction.
REQ-008 SHALL have port write_data, input, 32, store data from core.
REQ-009 SHALL have port read_data, output, 32, load data to core.
REQ-010 SHALL have port io_stall, output, 1, core must hold PC and the current instruction while high.
REQ-011 SHALL have port io_done, output, 1, one-cycle pulse on completion of a read or write.
REQ-012 SHALL have port switch_in, input, SW_W, raw asynchronous board switches.
REQ-013 SHALL have port confirm_btn, input, 1, raw asynchronous confirm button.
REQ-014 SHALL have port led_out, output, LED_W, registered LED drive.

Function
REQ-015 SHALL pass switch_in and confirm_btn through two-flop synchronisers before any use.
REQ-016 SHALL debounce the synchronised confirm_btn: counter runs while the synchronised value differs from btn_stable; btn_stable takes the new value when the counter reaches DB_CNT-1; counter clears on any agreement.
REQ-017 SHALL implement FSM states IDLE, WAIT_PRESS, WAIT_RELEASE and DONE.
REQ-018 SHALL, in IDLE with io_write=1 and io_read=0, load led_out with write_data[LED_W-1:0] at the next edge and pulse io_done in the following cycle; no stall; state stays IDLE.
REQ-019 SHALL, in IDLE with io_read=1 and io_write=0, go to WAIT_PRESS.
REQ-020 SHALL, in WAIT_PRESS with btn_stable=1, capture the synchronised switches, zero-extended, into read_data and go to WAIT_RELEASE.
REQ-021 SHALL, in WAIT_RELEASE with btn_stable=0, go to DONE.
REQ-022 SHALL, in DONE, assert io_done for one cycle and return to IDLE at the next edge.
REQ-023 SHALL drive io_stall = io_read AND (state != DONE), combinationally, so the core advances exactly at the DONE edge.
REQ-024 SHALL abort to IDLE if io_read drops in WAIT_PRESS or WAIT_RELEASE, without io_done and with read_data unchanged.
REQ-025 SHALL, with io_read and io_write both high, ignore both, make no state or output change, and keep io_stall low.
REQ-026 SHALL hold read_data from its last capture until the next capture.
REQ-027 SHALL hold led_out until the next accepted write.
REQ-028 SHALL treat a button already held when a read starts as not a press: WAIT_PRESS requires btn_stable to be 0 for at least one cycle before a rising level counts.
REQ-029 SHALL start a fresh transaction for back-to-back reads, with the IDLE cycle between them.

Reset
REQ-030 SHALL, on rst=1, immediately force: state IDLE, led_out 0, read_data 0, io_done 0, btn_stable 0, debounce counter 0, synchronisers 0.
REQ-031 SHALL treat reset mid-transaction as an abort: no io_done pulse; io_stall then follows REQ-023 from IDLE.

Structure
REQ-032 SHALL place the state enumeration and the defaults for SW_W, LED_W and DB_CNT in the shared project package or header.
REQ-033 SHALL implement the debounce counter and its synchroniser as one sub-module, io_debouncer, parameterised by DB_CNT; the switch synchronisers stay in io_responder.

Verification
REQ-034 SHALL cover write: io_write=1, write_data=0x0000_A5A5 for one cycle -> led_out=0xA5A5 at the next edge, io_done pulse one cycle later, io_stall never high.
REQ-035 SHALL cover read (DB_CNT=4): switch_in=0x1234, io_read held, button pressed for 10 cycles then released -> io_stall high until DONE, read_data=0x0000_1234, exactly one io_done pulse.
REQ-036 SHALL cover bounce (DB_CNT=4): button toggles every 2 cycles for 20 cycles -> btn_stable stays 0 and the FSM stays in WAIT_PRESS.
REQ-037 SHALL cover button held before the read starts: io_read asserts with btn_stable=1 -> no capture until a release then a press.
REQ-038 SHALL cover reset in WAIT_RELEASE: rst pulse -> state IDLE, read_data=0, led_out=0, no io_done pulse.
REQ-039 SHALL cover conflict: io_read=io_write=1 -> led_out and read_data unchanged, io_stall=0, io_done=0.

Source files
------------

// File: rtl/io_responder_pkg.sv
`default_nettype none
// ============================================================
// Package : io_responder_pkg
// Desc    : Shared FSM encoding and parameter defaults
// Rev     : 1.0
// ============================================================
package io_responder_pkg;

  localparam int c_SW_W   = 16;
  localparam int c_LED_W  = 16;
  localparam int c_DB_CNT = 500000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/io_debouncer.sv
`default_nettype none
// ============================================================
// Module : io_debouncer
// Desc   : Two-flop synchroniser plus stability-window debounce
// Rev    : 1.0
// ============================================================
module io_debouncer
  import io_responder_pkg::*;
#(
  parameter int DB_CNT = c_DB_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable
);

  localparam int             CW        = $clog2(DB_CNT);
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(DB_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Counter only advances while the synchronised input disagrees with the
  // accepted level; any agreement restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================
// Module : io_responder
// Desc   : Core IO responder: LED store, switch load gated by a button
// Rev    : 1.0
// ============================================================
module io_responder
  import io_responder_pkg::*;
#(
  parameter int SW_W   = c_SW_W,
  parameter int LED_W  = c_LED_W,
  parameter int DB_CNT = c_DB_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_read,
  input  logic             io_write,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  output logic             io_stall,
  output logic             io_done,
  input  logic [SW_W-1:0]  switch_in,
  input  logic             confirm_btn,
  output logic [LED_W-1:0] led_out
);

  logic [SW_W-1:0] r_sw_s1;
  logic [SW_W-1:0] r_sw_s2;
  logic            w_btn_stable;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_armed;
  logic            w_armed_nxt;
  logic            r_wr_done;
  logic            w_wr_accept;
  logic            w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= switch_in;
      r_sw_s2 <= r_sw_s1;
    end
  end

  io_debouncer #(
    .DB_CNT (DB_CNT)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (confirm_btn),
    .o_stable (w_btn_stable)
  );

  // r_armed records that the button was seen released during this read, so a
  // button already held when the read began is not taken as a press.
  always_comb begin
    w_state_nxt = r_state;
    w_armed_nxt = r_armed;
    w_wr_accept = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_armed_nxt = 1'b0;
        if (io_write && !io_read) begin
          w_wr_accept = 1'b1;
        end else if (io_read && !io_write) begin
          w_state_nxt = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!io_read) begin
          w_state_nxt = IDLE;
        end else if (!io_write) begin
          if (!w_btn_stable) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_capture   = 1'b1;
            w_state_nxt = WAIT_RELEASE;
          end
        end
      end
      WAIT_RELEASE: begin
        if (!io_read) begin
          w_state_nxt = IDLE;
        end else if (!io_write && !w_btn_stable) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_armed   <= 1'b0;
      r_wr_done <= 1'b0;
      led_out   <= '0;
      read_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_armed   <= w_armed_nxt;
      r_wr_done <= w_wr_accept;
      if (w_wr_accept) begin
        led_out <= write_data[LED_W-1:0];
      end
      if (w_capture) begin
        read_data <= 32'(r_sw_s2);
      end
    end
  end

  assign io_stall = io_read && !io_write && (r_state != DONE);
  assign io_done  = (r_state == DONE) || r_wr_done;

  generate
    if (LED_W < 32) begin : g_wdata_unused
      logic w_unused_wdata;
      assign w_unused_wdata = ^write_data[31:LED_W];
    end
  endgenerate

endmodule
`default_nettype wire
